// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Holds FSM, grant and region encodings plus the address-region helper.
package mem_arb_pkg;

   localparam logic [31:0] DEF_IMEM_CUTOFF = 32'h0000_00FF;
   localparam int          DEF_STARVE_LIMIT = 4;
   localparam int          DEF_TIMEOUT      = 1023;

   localparam logic [31:0] TIMEOUT_RESULT = 32'hDEAD_BEEF;
   localparam logic [1:0]  OPLEN_WORD     = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } arb_state_t;

   typedef enum logic {
      GNT_INSTR,
      GNT_DATA
   } gnt_t;

   typedef enum logic {
      REG_IRAM,
      REG_SDRAM
   } region_t;

   // The all-ones address is an internal-RAM alias on top of the low window.
   function automatic logic in_iram(
      input logic [31:0] addr,
      input logic [31:0] cutoff
   );
      return (addr < cutoff) || (addr == 32'hFFFF_FFFF);
   endfunction

endpackage

// File: rtl/mem_arbiter_region_decode.sv
// Combinational address-to-region decoder for the shared memory port.
// Ports: addr (request address) -> region (REG_IRAM / REG_SDRAM).
module region_decode
   import mem_arb_pkg::*;
#(
   parameter logic [31:0] IMEM_CUTOFF = DEF_IMEM_CUTOFF
) (
   input  logic [31:0] addr,
   output region_t     region
);

   always_comb begin
      region = REG_SDRAM;
      if (in_iram(addr, IMEM_CUTOFF))
         region = REG_IRAM;
   end

endmodule

// File: rtl/mem_arbiter.sv
// One-transaction-at-a-time arbiter between instruction fetch and data
// access sharing a single memory port, with anti-starvation and timeout.
// Ports: clk, rst (async high); instr_* / data_* requester side;
// mem_* downstream port; err_timeout sticky abort flag.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter logic [31:0] IMEM_CUTOFF  = DEF_IMEM_CUTOFF,
   parameter int          STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int          TIMEOUT      = DEF_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_enable,
   input  logic [31:0] instr_addr,
   output logic        instr_valid,
   output logic [31:0] instr_result,
   input  logic        data_enable,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic        data_we,
   input  logic [1:0]  data_oplen,
   input  logic        data_unsigned,
   output logic        data_valid,
   output logic [31:0] data_result,
   output logic        mem_enable,
   output logic        mem_sel,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic [1:0]  mem_oplen,
   output logic        mem_unsigned,
   input  logic        mem_valid,
   input  logic [31:0] mem_result,
   output logic        err_timeout
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] S_LIM   = SW'(STARVE_LIMIT);

   arb_state_t    state;
   arb_state_t    state_nxt;
   gnt_t          gnt_q;
   gnt_t          gnt_nxt;
   region_t       req_region;
   logic [SW-1:0] starve_cnt;
   logic [TW-1:0] to_cnt;

   logic          data_wins;
   logic          start;
   logic          fin_ok;
   logic          fin_to;
   logic          to_hit;
   logic [31:0]   req_addr;
   logic [31:0]   fin_res;

   region_decode #(
      .IMEM_CUTOFF (IMEM_CUTOFF)
   ) u_region_decode (
      .addr   (req_addr),
      .region (req_region)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (instr_enable || data_enable)
               state_nxt = WAIT;
         WAIT:
            if (mem_valid || to_hit)
               state_nxt = DONE;
         DONE:
            state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   // Decision strobes for the datapath
   always_comb begin
      data_wins = data_enable &&
                  (!instr_enable || (starve_cnt == S_LIM));
      gnt_nxt   = data_wins ? GNT_DATA : GNT_INSTR;
      req_addr  = data_wins ? data_addr : instr_addr;
      to_hit    = (to_cnt == TO_LAST);
      start     = (state == IDLE) && (instr_enable || data_enable);
      fin_ok    = (state == WAIT) && mem_valid;
      // A response arriving on the last WAIT cycle beats the abort.
      fin_to    = (state == WAIT) && !mem_valid && to_hit;
      fin_res   = fin_ok ? mem_result : TIMEOUT_RESULT;
   end

   // Grant, counters and the registered memory port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q        <= GNT_INSTR;
         starve_cnt   <= '0;
         to_cnt       <= '0;
         mem_enable   <= 1'b0;
         mem_sel      <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_we       <= 1'b0;
         mem_oplen    <= '0;
         mem_unsigned <= 1'b0;
      end else begin
         if (start) begin
            gnt_q      <= gnt_nxt;
            to_cnt     <= '0;
            mem_enable <= 1'b1;
            mem_sel    <= (req_region == REG_SDRAM);
            mem_addr   <= req_addr;
            if (data_wins) begin
               starve_cnt   <= '0;
               mem_wdata    <= data_wdata;
               mem_we       <= data_we;
               mem_oplen    <= data_oplen;
               mem_unsigned <= data_unsigned;
            end else begin
               if (data_enable && (starve_cnt != S_LIM))
                  starve_cnt <= starve_cnt + 1'b1;
               mem_wdata    <= '0;
               mem_we       <= 1'b0;
               mem_oplen    <= OPLEN_WORD;
               mem_unsigned <= 1'b0;
            end
         end
         if (state == WAIT)
            to_cnt <= to_cnt + 1'b1;
         if (fin_ok || fin_to)
            mem_enable <= 1'b0;
      end
   end

   // Requester-side results, valid pulses and the sticky abort flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_valid  <= 1'b0;
         instr_result <= '0;
         data_valid   <= 1'b0;
         data_result  <= '0;
         err_timeout  <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         data_valid  <= 1'b0;
         if (fin_ok || fin_to) begin
            if (gnt_q == GNT_DATA) begin
               data_valid  <= 1'b1;
               data_result <= fin_res;
            end else begin
               instr_valid  <= 1'b1;
               instr_result <= fin_res;
            end
         end
         if (fin_to)
            err_timeout <= 1'b1;
      end
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing one downstream memory port between the core's instruction-fetch and data-access requesters. It grants one requester at a time and locks the grant until the memory responds. It selects the target region (internal RAM or SDRAM) from the address, prevents data-side starvation and aborts hung transactions with a timeout. It sits between the core and the internal RAM / SDRAM controller pair, replacing ad-hoc per-cycle muxing with a registered, one-transaction-at-a-time scheduler.

## Interface
- IMEM_CUTOFF, 32'h0000_00FF: addresses below this, plus 32'hFFFF_FFFF, route to internal RAM (mem_sel=0); all others go to SDRAM (mem_sel=1).
- STARVE_LIMIT, 4: consecutive instr grants allowed while data_enable is pending.
- TIMEOUT, 1023: WAIT cycles before abort; counter width $clog2(TIMEOUT+1).
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- instr_enable  in  1 / instr_addr  in  32 / instr_valid  out  1 / instr_result  out  32.
- data_enable  in  1 / data_addr  in  32 / data_wdata  in  32 / data_we  in  1 / data_oplen  in  2 / data_unsigned  in  1.
- data_valid  out  1 / data_result  out  32 (raw, unextended).
- mem_enable  out  1 / mem_sel  out  1 / mem_addr  out  32 / mem_wdata  out  32 / mem_we  out  1 / mem_oplen  out  2 / mem_unsigned  out  1.
- mem_valid  in  1 / mem_result  in  32 (from the selected region).
- err_timeout  out  1  sticky abort flag.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if any enable is high, grant and latch all mem_* fields, then go to WAIT with mem_enable=1.
- Instr grant forces mem_we=0, mem_oplen=3, mem_unsigned=0, mem_wdata=0.
- Priority: instr wins by default. Data wins if instr_enable is low, or if starve_cnt==STARVE_LIMIT.
- starve_cnt increments on each instr grant while data_enable is high. It clears on any data grant and saturates at STARVE_LIMIT.
- WAIT: mem_enable and all mem_* fields stay stable. Requester inputs are ignored.
  - On mem_valid: capture mem_result into the granted requester's result register, pulse that requester's valid, drop mem_enable, go to DONE.
  - If to_cnt reaches TIMEOUT without mem_valid: drop mem_enable, return result 32'hDEAD_BEEF with a valid pulse, set err_timeout, go to DONE.
  - mem_valid and the timeout in the same cycle: mem_valid wins and err_timeout is not set.
- DONE: valid is high for this single cycle. The requester must drop or renew its enable. Enables are ignored this cycle. Next state is IDLE.
- mem_valid outside WAIT is ignored.
- Result registers hold their last value between transactions. The non-granted valid stays 0.
- err_timeout clears only on rst.

## Timing
- Reset (asynchronous, immediate): state=IDLE; mem_enable, mem_we, mem_sel, instr_valid, data_valid, err_timeout = 0; all data/addr outputs = 0; starve_cnt and to_cnt = 0.
- Reset mid-transaction drops mem_enable at once and discards the response.
- Enable sampled at edge N in IDLE gives mem_enable high from N+1.
- mem_valid sampled at edge M gives the requester valid high for exactly cycle M+1, then low.
- Best-case latency (mem_valid in the first WAIT cycle): requester valid 2 cycles after the enable edge.
- Throughput: one transaction per 3 cycles at best.
- to_cnt clears on entering WAIT and increments every WAIT cycle.

## Structure
- Shared package mem_arb_pkg:
  - state enum arb_state_t {IDLE, WAIT, DONE};
  - grant enum {GNT_INSTR, GNT_DATA};
  - region enum {REG_IRAM, REG_SDRAM};
  - TIMEOUT_RESULT = 32'hDEAD_BEEF.
- One sub-module, region_decode: combinational address → mem_sel using IMEM_CUTOFF and the all-ones address.
- The FSM, counters and registers stay in mem_arbiter.

## Test plan
- Instr-only fetch at 0x10, memory answers 0x0000_0013 after 1 cycle → mem_sel=0, mem_oplen=3, instr_valid high one cycle with 0x13, data_valid stays 0.
- Simultaneous instr 0x20 and data write to 0x1000 (wdata 0xCAFEF00D, oplen 2) → instr served first. Data follows with mem_sel=1, mem_we=1, and mem_wdata stable during WAIT.
- Continuous instr_enable plus pending data, STARVE_LIMIT=4 → exactly 4 instr grants, then one data grant, after which starve_cnt resets.
- mem_valid never asserted with TIMEOUT=15 → mem_enable drops after 15 WAIT cycles, data_valid pulses with 0xDEAD_BEEF, err_timeout=1 until rst.
- rst asserted mid-WAIT at a random cycle → all outputs 0 without waiting for a clock edge. A later mem_valid is ignored and the next request proceeds normally.
- Data read at 0xFFFF_FFFF and at 0x0000_00FF → first routes to mem_sel=0, second to mem_sel=1. mem_valid pulses in IDLE/DONE produce no valid.
